// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: operand/destination tags from the pipeline
// stages in, stall/flush/forwarding controls out.
// With HAZARD_PERF_EN defined the bundle also carries the two perf counters.
interface hazard_ctrl_if;
    logic [4:0]  rs1_d;
    logic [4:0]  rs2_d;
    logic [4:0]  rs1_e;
    logic [4:0]  rs2_e;
    logic [4:0]  rd_e;
    logic        rd_write_e;
    logic [1:0]  rd_write_src_e;
    logic        pc_write_e;
    logic        mc_req_e;
    logic [4:0]  rd_m;
    logic        rd_write_m;
    logic [4:0]  rd_w;
    logic        rd_write_w;
    logic        stall_f;
    logic        stall_d;
    logic        stall_e;
    logic        flush_d;
    logic        flush_e;
    logic [1:0]  forwarding_rs1_e;
    logic [1:0]  forwarding_rs2_e;
    logic        mc_start;
    logic        mc_busy;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_write_e, rd_write_src_e,
               pc_write_e, mc_req_e, rd_m, rd_write_m, rd_w, rd_write_w,
        input  stall_f, stall_d, stall_e, flush_d, flush_e,
               forwarding_rs1_e, forwarding_rs2_e, mc_start, mc_busy,
               perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_write_e, rd_write_src_e,
               pc_write_e, mc_req_e, rd_m, rd_write_m, rd_w, rd_write_w,
        output stall_f, stall_d, stall_e, flush_d, flush_e,
               forwarding_rs1_e, forwarding_rs2_e, mc_start, mc_busy,
               perf_stall_cnt, perf_flush_cnt
    );
`else
    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_write_e, rd_write_src_e,
               pc_write_e, mc_req_e, rd_m, rd_write_m, rd_w, rd_write_w,
        input  stall_f, stall_d, stall_e, flush_d, flush_e,
               forwarding_rs1_e, forwarding_rs2_e, mc_start, mc_busy
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_write_e, rd_write_src_e,
               pc_write_e, mc_req_e, rd_m, rd_write_m, rd_w, rd_write_w,
        output stall_f, stall_d, stall_e, flush_d, flush_e,
               forwarding_rs1_e, forwarding_rs2_e, mc_start, mc_busy
    );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central hazard controller for the five-stage pipeline.
// Produces fetch/decode/execute stall and flush, execute-stage operand
// forwarding selects, and sequences iterative multi-cycle execute ops by
// holding the pipeline for MC_LATENCY-1 cycles.
// Optional feature macro: HAZARD_PERF_EN adds perf_stall_cnt/perf_flush_cnt.
module hazard_ctrl #(
    parameter int MC_LATENCY = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    typedef enum logic {IDLE, BUSY} state_t;

    // A latency of 1 means the op completes in its own execute cycle.
    localparam logic       MC_MULTI = (MC_LATENCY > 1);
    localparam logic [7:0] MC_LOAD  = (MC_LATENCY > 1) ? 8'(MC_LATENCY - 2) : 8'd0;

    state_t     state;
    logic [7:0] cnt;

    logic       mc_start_c;
    logic       mc_hold_c;
    logic       load_use_c;
    logic       stall_f_c;
    logic       stall_d_c;
    logic       stall_e_c;
    logic       flush_d_c;
    logic       flush_e_c;
    logic [1:0] fwd1_c;
    logic [1:0] fwd2_c;

    // Memory-stage result is younger than writeback, so it wins.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            return 2'b10;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Multi-cycle sequencer: load the counter on op start, count down while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (hz.mc_req_e && MC_MULTI) begin
                        state <= BUSY;
                        cnt   <= MC_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt != 8'd0)
                        cnt <= cnt - 8'd1;
                    else
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

    // Stall/flush/forward decision. The op start and the countdown must act
    // in the request cycle itself, so these are decoded from the FSM state
    // and the live inputs rather than registered.
    always_comb begin
        mc_start_c = 1'b0;
        mc_hold_c  = 1'b0;
        load_use_c = 1'b0;
        stall_f_c  = 1'b0;
        stall_d_c  = 1'b0;
        stall_e_c  = 1'b0;
        flush_d_c  = 1'b0;
        flush_e_c  = 1'b0;
        fwd1_c     = 2'b00;
        fwd2_c     = 2'b00;
        if (!rst) begin
            fwd1_c = fwd_sel(hz.rs1_e, hz.rd_m, hz.rd_write_m, hz.rd_w, hz.rd_write_w);
            fwd2_c = fwd_sel(hz.rs2_e, hz.rd_m, hz.rd_write_m, hz.rd_w, hz.rd_write_w);

            // In BUSY with cnt==0 the op advances and mc_req_e is not re-sampled.
            mc_start_c = (state == IDLE) && hz.mc_req_e && MC_MULTI;
            mc_hold_c  = mc_start_c || ((state == BUSY) && (cnt != 8'd0));

            load_use_c = hz.rd_write_e && (hz.rd_write_src_e == 2'b01) &&
                         (hz.rd_e != 5'd0) &&
                         ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

            // Priority: multi-cycle hold > taken branch > load-use bubble.
            if (mc_hold_c) begin
                stall_f_c = 1'b1;
                stall_d_c = 1'b1;
                stall_e_c = 1'b1;
            end else if (hz.pc_write_e) begin
                flush_d_c = 1'b1;
                flush_e_c = 1'b1;
            end else if (load_use_c) begin
                stall_f_c = 1'b1;
                stall_d_c = 1'b1;
                flush_e_c = 1'b1;
            end
        end
    end

    assign hz.stall_f          = stall_f_c;
    assign hz.stall_d          = stall_d_c;
    assign hz.stall_e          = stall_e_c;
    assign hz.flush_d          = flush_d_c;
    assign hz.flush_e          = flush_e_c;
    assign hz.forwarding_rs1_e = fwd1_c;
    assign hz.forwarding_rs2_e = fwd2_c;
    assign hz.mc_start         = mc_start_c;
    assign hz.mc_busy          = mc_hold_c;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    // Free-running event counters; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            if (stall_f_c)
                perf_stall_q <= perf_stall_q + 32'd1;
            if (flush_d_c)
                perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign hz.perf_stall_cnt = perf_stall_q;
    assign hz.perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (MC_LATENCY 4 and 1) share one
// stimulus stream; expected outputs come from a cycle-index reference model
// and are queued for a monitor that compares on the falling edge.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1_d;
        logic [4:0] rs2_d;
        logic [4:0] rs1_e;
        logic [4:0] rs2_e;
        logic [4:0] rd_e;
        logic       rd_write_e;
        logic [1:0] src_e;
        logic       pc_write_e;
        logic       mc_req_e;
        logic [4:0] rd_m;
        logic       rd_write_m;
        logic [4:0] rd_w;
        logic       rd_write_w;
    } in_t;

    typedef struct packed {
        logic       stall_f;
        logic       stall_d;
        logic       stall_e;
        logic       flush_d;
        logic       flush_e;
        logic [1:0] fwd1;
        logic [1:0] fwd2;
        logic       mc_start;
        logic       mc_busy;
    } out_t;

    localparam int LAT_A = 4;
    localparam int LAT_B = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if ifa ();
    hazard_ctrl_if ifb ();

    hazard_ctrl #(.MC_LATENCY(LAT_A)) dut_a (.clk(clk), .rst(rst), .hz(ifa));
    hazard_ctrl #(.MC_LATENCY(LAT_B)) dut_b (.clk(clk), .rst(rst), .hz(ifb));

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    out_t qa[$];
    out_t qb[$];
    // Model: -1 = no op in flight, otherwise cycles elapsed since op start.
    int ph_a = -1;
    int ph_b = -1;
`ifdef HAZARD_PERF_EN
    logic [31:0] ps_a = 0, pf_a = 0, ps_b = 0, pf_b = 0;
    logic [63:0] qpa[$];
    logic [63:0] qpb[$];
`endif

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, exp);
    endtask

    function automatic logic [1:0] ref_fwd(input in_t x, input logic [4:0] rs);
        if (x.rd_write_m && x.rd_m != 0 && x.rd_m == rs) return 2'b10;
        if (x.rd_write_w && x.rd_w != 0 && x.rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Op occupies execute for L cycles: cycles 0..L-2 stall, cycle L-1 advances.
    function automatic out_t ref_eval(input in_t x, input int ph, input int lat);
        out_t o;
        bit   start, hold, lu;
        o = '0;
        if (x.rst) return o;
        o.fwd1 = ref_fwd(x, x.rs1_e);
        o.fwd2 = ref_fwd(x, x.rs2_e);
        start = (ph < 0) && x.mc_req_e && (lat > 1);
        hold  = start || (ph >= 1 && ph < lat - 1);
        lu    = x.rd_write_e && x.src_e == 2'b01 && x.rd_e != 0 &&
                (x.rd_e == x.rs1_d || x.rd_e == x.rs2_d);
        if (hold) begin
            o.stall_f = 1; o.stall_d = 1; o.stall_e = 1;
            o.mc_busy = 1; o.mc_start = start;
        end else if (x.pc_write_e) begin
            o.flush_d = 1; o.flush_e = 1;
        end else if (lu) begin
            o.stall_f = 1; o.stall_d = 1; o.flush_e = 1;
        end
        return o;
    endfunction

    function automatic int ref_next(input in_t x, input int ph, input int lat);
        if (x.rst) return -1;
        if (ph < 0) return (x.mc_req_e && lat > 1) ? 1 : -1;
        return (ph >= lat - 1) ? -1 : ph + 1;
    endfunction

    task automatic apply(input in_t x);
        rst = x.rst;
        ifa.rs1_d = x.rs1_d; ifb.rs1_d = x.rs1_d;
        ifa.rs2_d = x.rs2_d; ifb.rs2_d = x.rs2_d;
        ifa.rs1_e = x.rs1_e; ifb.rs1_e = x.rs1_e;
        ifa.rs2_e = x.rs2_e; ifb.rs2_e = x.rs2_e;
        ifa.rd_e = x.rd_e;   ifb.rd_e = x.rd_e;
        ifa.rd_write_e = x.rd_write_e; ifb.rd_write_e = x.rd_write_e;
        ifa.rd_write_src_e = x.src_e;  ifb.rd_write_src_e = x.src_e;
        ifa.pc_write_e = x.pc_write_e; ifb.pc_write_e = x.pc_write_e;
        ifa.mc_req_e = x.mc_req_e;     ifb.mc_req_e = x.mc_req_e;
        ifa.rd_m = x.rd_m; ifb.rd_m = x.rd_m;
        ifa.rd_write_m = x.rd_write_m; ifb.rd_write_m = x.rd_write_m;
        ifa.rd_w = x.rd_w; ifb.rd_w = x.rd_w;
        ifa.rd_write_w = x.rd_write_w; ifb.rd_write_w = x.rd_write_w;
    endtask

    // One clock of stimulus: drive after the edge, queue expectations, advance model.
    task automatic step(input in_t x);
        out_t ea, eb;
        @(posedge clk);
        #1;
        apply(x);
        ea = ref_eval(x, ph_a, LAT_A);
        eb = ref_eval(x, ph_b, LAT_B);
        qa.push_back(ea);
        qb.push_back(eb);
`ifdef HAZARD_PERF_EN
        qpa.push_back({ps_a, pf_a});
        qpb.push_back({ps_b, pf_b});
        ps_a = x.rst ? 32'd0 : ps_a + 32'(ea.stall_f);
        pf_a = x.rst ? 32'd0 : pf_a + 32'(ea.flush_d);
        ps_b = x.rst ? 32'd0 : ps_b + 32'(eb.stall_f);
        pf_b = x.rst ? 32'd0 : pf_b + 32'(eb.flush_d);
`endif
        ph_a = ref_next(x, ph_a, LAT_A);
        ph_b = ref_next(x, ph_b, LAT_B);
    endtask

    function automatic in_t rand_in();
        in_t x;
        x.rst        = ($urandom_range(0, 49) == 0);
        x.rs1_d      = 5'($urandom_range(0, 3));
        x.rs2_d      = 5'($urandom_range(0, 3));
        x.rs1_e      = 5'($urandom_range(0, 3));
        x.rs2_e      = 5'($urandom_range(0, 3));
        x.rd_e       = 5'($urandom_range(0, 3));
        x.rd_write_e = 1'($urandom_range(0, 1));
        x.src_e      = 2'($urandom_range(0, 3));
        x.pc_write_e = ($urandom_range(0, 5) == 0);
        x.mc_req_e   = ($urandom_range(0, 9) == 0);
        x.rd_m       = 5'($urandom_range(0, 3));
        x.rd_write_m = 1'($urandom_range(0, 1));
        x.rd_w       = 5'($urandom_range(0, 3));
        x.rd_write_w = 1'($urandom_range(0, 1));
        return x;
    endfunction

    // Monitor: compare whatever the driver queued for this cycle.
    initial begin
        out_t e;
        forever begin
            @(negedge clk);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("outs_lat4",
                    64'({ifa.stall_f, ifa.stall_d, ifa.stall_e, ifa.flush_d, ifa.flush_e,
                         ifa.forwarding_rs1_e, ifa.forwarding_rs2_e, ifa.mc_start, ifa.mc_busy}),
                    64'(e));
            end
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("outs_lat1",
                    64'({ifb.stall_f, ifb.stall_d, ifb.stall_e, ifb.flush_d, ifb.flush_e,
                         ifb.forwarding_rs1_e, ifb.forwarding_rs2_e, ifb.mc_start, ifb.mc_busy}),
                    64'(e));
            end
`ifdef HAZARD_PERF_EN
            if (qpa.size() != 0)
                chk("perf_lat4", {ifa.perf_stall_cnt, ifa.perf_flush_cnt}, qpa.pop_front());
            if (qpb.size() != 0)
                chk("perf_lat1", {ifb.perf_stall_cnt, ifb.perf_flush_cnt}, qpb.pop_front());
`endif
            cyc++;
        end
    end

    initial begin
        in_t x;
        // Reset
        x = '0; x.rst = 1;
        step(x); step(x);
        x.rst = 0;
        step(x);
        // Load-use on rs2, then the load has moved on
        x = '0; x.rd_e = 3; x.src_e = 2'b01; x.rd_write_e = 1; x.rs2_d = 3;
        step(x);
        x = '0; step(x);
        // Branch together with a load-use condition
        x = '0; x.rd_e = 3; x.src_e = 2'b01; x.rd_write_e = 1; x.rs1_d = 3; x.pc_write_e = 1;
        step(x);
        // Multi-cycle op, request held for the full occupancy
        x = '0; x.mc_req_e = 1;
        repeat (4) step(x);
        x = '0; step(x);
        // Load-use with rd_e == 0 must not stall
        x = '0; x.src_e = 2'b01; x.rd_write_e = 1; x.rd_e = 0; x.rs2_d = 0;
        step(x);
        // Forwarding priority
        x = '0; x.rs1_e = 5; x.rs2_e = 5; x.rd_m = 5; x.rd_write_m = 1; x.rd_w = 5; x.rd_write_w = 1;
        step(x);
        x.rd_write_m = 0; step(x);
        x.rd_m = 0; x.rd_w = 0; x.rs1_e = 0; x.rd_write_m = 1; step(x);
        // Multi-cycle and branch together: branch released with the op
        x = '0; x.mc_req_e = 1; x.pc_write_e = 1;
        repeat (4) step(x);
        x = '0; step(x);
        // Reset during BUSY cycle 1, then a fresh op
        x = '0; x.mc_req_e = 1; step(x);
        x.rst = 1; step(x);
        x = '0; step(x);
        x.mc_req_e = 1; step(x);
        x = '0; repeat (4) step(x);
        // Randomized traffic
        for (int i = 0; i < 500; i++) step(rand_in());
        x = '0; step(x);
        @(negedge clk);
        #1;
        chk("queue_drain", 64'(qa.size() + qb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
